// File: rtl/cdp_dp_intp_mul_unit_pkg.sv
// Shared CDP datapath definitions: operand/result widths, int16 saturation limits
// and the round-shift-saturate helper reused by the multiplier and output converter.
package cdp_dp_intp_mul_unit_pkg;

    localparam int CDP_INTP_DW = 17;
    localparam int CDP_OUT_DW  = 16;
    localparam int CDP_PROD_W  = 2 * CDP_INTP_DW;
    localparam int CDP_SHIFT_W = 5;

    localparam logic [CDP_OUT_DW-1:0] CDP_SAT_MAX = 16'h7FFF;
    localparam logic [CDP_OUT_DW-1:0] CDP_SAT_MIN = 16'h8000;

    localparam logic signed [CDP_PROD_W:0] CDP_RND_ONE = {{CDP_PROD_W{1'b0}}, 1'b1};

    typedef struct packed {
        logic [CDP_OUT_DW-1:0] pd;
        logic                  sat;
    } cdp_sat_res_t;

    // One joined beat as held in stage 0: product plus the per-beat config.
    typedef struct packed {
        logic [CDP_PROD_W-1:0]  prod;
        logic [CDP_INTP_DW-1:0] dat;
        logic [CDP_SHIFT_W-1:0] shift;
        logic                   bypass;
    } cdp_mul_beat_t;

    function automatic cdp_sat_res_t cdp_round_shift_sat(
        input logic signed [CDP_PROD_W-1:0]  val,
        input logic        [CDP_SHIFT_W-1:0] shift
    );
        logic signed [CDP_PROD_W:0] ext;
        logic signed [CDP_PROD_W:0] r;
        cdp_sat_res_t               res;
        // One extra bit of headroom so the rounding add can never overflow.
        ext = {val[CDP_PROD_W-1], val};
        if (shift == '0) begin
            r = ext;
        end else begin
            r = (ext + (CDP_RND_ONE <<< (shift - 1'b1))) >>> shift;
        end
        // In int16 range only when every bit above the int16 sign bit matches the sign.
        if (r[CDP_PROD_W:CDP_OUT_DW-1] == {(CDP_PROD_W-CDP_OUT_DW+2){r[CDP_PROD_W]}}) begin
            res.pd  = r[CDP_OUT_DW-1:0];
            res.sat = 1'b0;
        end else begin
            res.pd  = r[CDP_PROD_W] ? CDP_SAT_MIN : CDP_SAT_MAX;
            res.sat = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/cdp_dp_join2.sv
// Two-input valid/ready join: a beat passes only when both sides are valid, and
// each side's ready never depends on its own valid.
module cdp_dp_join2 (
    input  logic a_vld,
    input  logic b_vld,
    input  logic out_rdy,
    output logic a_rdy,
    output logic b_rdy,
    output logic out_vld
);

    assign out_vld = a_vld & b_vld;
    assign a_rdy   = b_vld & out_rdy;
    assign b_rdy   = a_vld & out_rdy;

endmodule

// File: rtl/cdp_dp_intp_mul_unit.sv
// CDP interpolation multiplier: joins data with its LRN coefficient, multiplies,
// round-shifts and saturates to int16 over a two-register valid/ready pipeline.
module cdp_dp_intp_mul_unit
    import cdp_dp_intp_mul_unit_pkg::*;
#(
    parameter int DW = CDP_INTP_DW,
    parameter int OW = CDP_OUT_DW,
    parameter int CW = 32
) (
    input  logic                   nvdla_core_clk,
    input  logic                   nvdla_core_rstn,
    input  logic [DW-1:0]          dat_in_pd,
    input  logic                   dat_in_vld,
    output logic                   dat_in_rdy,
    input  logic [DW-1:0]          intp_in_pd,
    input  logic                   intp_in_vld,
    output logic                   intp_in_rdy,
    input  logic [CDP_SHIFT_W-1:0] cfg_mul_shift,
    input  logic                   cfg_mul_bypass,
    input  logic                   cnt_clr,
    output logic [OW-1:0]          mul_out_pd,
    output logic                   mul_out_vld,
    input  logic                   mul_out_rdy,
    output logic [CW-1:0]          sat_cnt
);

    logic                          join_vld;
    logic                          in_load;
    logic                          s0_vld;
    logic                          s0_rdy;
    logic                          s1_rdy;
    logic                          out_load;
    logic signed [DW-1:0]          dat_s;
    logic signed [DW-1:0]          intp_s;
    logic signed [CDP_PROD_W-1:0]  prod;
    cdp_mul_beat_t                 s0_q;
    logic signed [CDP_PROD_W-1:0]  s1_val;
    logic        [CDP_SHIFT_W-1:0] s1_shift;
    cdp_sat_res_t                  s1_res;
    logic                          sat_load;

    cdp_dp_join2 u_join (
        .a_vld   (dat_in_vld),
        .b_vld   (intp_in_vld),
        .out_rdy (s0_rdy),
        .a_rdy   (dat_in_rdy),
        .b_rdy   (intp_in_rdy),
        .out_vld (join_vld)
    );

    assign s1_rdy   = ~mul_out_vld | mul_out_rdy;
    assign s0_rdy   = ~s0_vld | s1_rdy;
    assign in_load  = join_vld & s0_rdy;
    assign out_load = s0_vld & s1_rdy;

    assign dat_s  = dat_in_pd;
    assign intp_s = intp_in_pd;
    assign prod   = CDP_PROD_W'(dat_s) * CDP_PROD_W'(intp_s);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            s0_vld <= 1'b0;
            s0_q   <= '0;
        end else begin
            if (in_load) begin
                s0_vld      <= 1'b1;
                s0_q.prod   <= prod;
                s0_q.dat    <= dat_in_pd;
                s0_q.shift  <= cfg_mul_shift;
                s0_q.bypass <= cfg_mul_bypass;
            end else if (s1_rdy) begin
                s0_vld <= 1'b0;
            end
        end
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        s1_val   = $signed(s0_q.prod);
        s1_shift = s0_q.shift;
        if (s0_q.bypass) begin
            s1_val   = CDP_PROD_W'($signed(s0_q.dat));
            s1_shift = '0;
        end
        s1_res = cdp_round_shift_sat(s1_val, s1_shift);
    end

    assign sat_load = out_load & s1_res.sat;

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            mul_out_vld <= 1'b0;
            mul_out_pd  <= '0;
        end else begin
            if (out_load) begin
                mul_out_vld <= 1'b1;
                mul_out_pd  <= s1_res.pd;
            end else if (mul_out_rdy) begin
                mul_out_vld <= 1'b0;
            end
        end
    end

    // Clear wins over increment, but a saturated load in the clear cycle still counts.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            sat_cnt <= '0;
        end else if (cnt_clr) begin
            sat_cnt <= sat_load ? CW'(1) : '0;
        end else if (sat_load && (sat_cnt != {CW{1'b1}})) begin
            sat_cnt <= sat_cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_cdp_dp_intp_mul_unit.sv
// Bench for cdp_dp_intp_mul_unit: directed scenarios plus randomized traffic scored
// against an arithmetic reference model; a narrow-counter instance checks sticking.
module tb_cdp_dp_intp_mul_unit;

    typedef struct {
        logic [15:0] pd;
        logic        sat;
    } exp_t;

    logic        nvdla_core_clk = 1'b0;
    logic        nvdla_core_rstn;
    logic [16:0] dat_in_pd;
    logic        dat_in_vld;
    logic        dat_in_rdy;
    logic [16:0] intp_in_pd;
    logic        intp_in_vld;
    logic        intp_in_rdy;
    logic [4:0]  cfg_mul_shift;
    logic        cfg_mul_bypass;
    logic        cnt_clr;
    logic [15:0] mul_out_pd;
    logic        mul_out_vld;
    logic        mul_out_rdy;
    logic [31:0] sat_cnt;

    logic        dat_in_rdy_s;
    logic        intp_in_rdy_s;
    logic [15:0] mul_out_pd_s;
    logic        mul_out_vld_s;
    logic [2:0]  sat_cnt_s;

    int          n_chk = 0;
    int          n_pass = 0;
    exp_t        exp_q[$];
    logic [31:0] exp_cnt;
    logic [2:0]  exp_cnt_s;
    logic        prev_vld, prev_rdy, prev_clr;
    logic [15:0] prev_pd;
    int          out_count = 0;
    int          fire_count = 0;

    logic        s_fire, s_out_vld, s_out_rdy, s_dat_rdy, s_intp_rdy;
    logic [15:0] s_out_pd;
    logic [31:0] s_sat_cnt;
    logic [2:0]  s_sat_cnt_s;

    always #5 nvdla_core_clk = ~nvdla_core_clk;

    cdp_dp_intp_mul_unit dut (
        .nvdla_core_clk  (nvdla_core_clk),
        .nvdla_core_rstn (nvdla_core_rstn),
        .dat_in_pd       (dat_in_pd),
        .dat_in_vld      (dat_in_vld),
        .dat_in_rdy      (dat_in_rdy),
        .intp_in_pd      (intp_in_pd),
        .intp_in_vld     (intp_in_vld),
        .intp_in_rdy     (intp_in_rdy),
        .cfg_mul_shift   (cfg_mul_shift),
        .cfg_mul_bypass  (cfg_mul_bypass),
        .cnt_clr         (cnt_clr),
        .mul_out_pd      (mul_out_pd),
        .mul_out_vld     (mul_out_vld),
        .mul_out_rdy     (mul_out_rdy),
        .sat_cnt         (sat_cnt)
    );

    cdp_dp_intp_mul_unit #(.CW(3)) dut_small (
        .nvdla_core_clk  (nvdla_core_clk),
        .nvdla_core_rstn (nvdla_core_rstn),
        .dat_in_pd       (dat_in_pd),
        .dat_in_vld      (dat_in_vld),
        .dat_in_rdy      (dat_in_rdy_s),
        .intp_in_pd      (intp_in_pd),
        .intp_in_vld     (intp_in_vld),
        .intp_in_rdy     (intp_in_rdy_s),
        .cfg_mul_shift   (cfg_mul_shift),
        .cfg_mul_bypass  (cfg_mul_bypass),
        .cnt_clr         (cnt_clr),
        .mul_out_pd      (mul_out_pd_s),
        .mul_out_vld     (mul_out_vld_s),
        .mul_out_rdy     (mul_out_rdy),
        .sat_cnt         (sat_cnt_s)
    );

    // Reference: exact integer product, round half up by floor((p + 2^(s-1)) / 2^s), clamp.
    function automatic exp_t model(input logic [16:0] d, input logic [16:0] c,
                                   input logic [4:0] s, input logic b);
        longint dv, cv, r, div;
        exp_t   e;
        dv = longint'($signed(d));
        cv = longint'($signed(c));
        if (b) begin
            r = dv;
        end else begin
            r = dv * cv;
            if (s != 5'd0) begin
                div = longint'(1) << s;
                r   = r + div / 2;
                if (r >= 0) r = r / div;
                else        r = -((-r + div - 1) / div);
            end
        end
        if (r > 32767) begin
            e.pd = 16'h7FFF; e.sat = 1'b1;
        end else if (r < -32768) begin
            e.pd = 16'h8000; e.sat = 1'b1;
        end else begin
            e.pd = 16'(r); e.sat = 1'b0;
        end
        return e;
    endfunction

    // One clock: observe and score at the falling edge, return 1 time unit after the rising edge.
    task automatic cycle();
        logic dat_fire, intp_fire, new_beat, new_sat;
        exp_t e;
        @(negedge nvdla_core_clk);
        s_out_vld   = mul_out_vld;
        s_out_rdy   = mul_out_rdy;
        s_out_pd    = mul_out_pd;
        s_sat_cnt   = sat_cnt;
        s_sat_cnt_s = sat_cnt_s;
        s_dat_rdy   = dat_in_rdy;
        s_intp_rdy  = intp_in_rdy;
        s_fire      = 1'b0;
        if (!nvdla_core_rstn) begin
            exp_q.delete();
            exp_cnt   = '0;
            exp_cnt_s = '0;
            prev_vld  = 1'b0;
            prev_rdy  = 1'b0;
            prev_clr  = 1'b0;
            prev_pd   = '0;
        end else begin
            if (prev_vld && !prev_rdy) begin
                n_chk++;
                if (mul_out_vld !== 1'b1 || mul_out_pd !== prev_pd)
                    $display("FAIL stall_hold: vld=%b pd=%h, required vld=1 pd=%h", mul_out_vld, mul_out_pd, prev_pd);
                else n_pass++;
            end
            new_beat = mul_out_vld && (!prev_vld || prev_rdy);
            new_sat  = 1'b0;
            if (new_beat) begin
                n_chk++;
                if (exp_q.size() == 0) $display("FAIL unexpected_output: pd=%h with no beat joined", mul_out_pd);
                else begin n_pass++; new_sat = exp_q[0].sat; end
            end
            if (prev_clr) begin
                exp_cnt   = new_sat ? 32'd1 : 32'd0;
                exp_cnt_s = new_sat ? 3'd1 : 3'd0;
            end else if (new_sat) begin
                if (exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 32'd1;
                if (exp_cnt_s != 3'd7) exp_cnt_s = exp_cnt_s + 3'd1;
            end
            n_chk++;
            if (sat_cnt !== exp_cnt) $display("FAIL sat_cnt: got %0d, required %0d", sat_cnt, exp_cnt);
            else n_pass++;
            n_chk++;
            if (sat_cnt_s !== exp_cnt_s) $display("FAIL sat_cnt_narrow: got %0d, required %0d", sat_cnt_s, exp_cnt_s);
            else n_pass++;
            if (mul_out_vld && mul_out_rdy && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                out_count++;
                n_chk++;
                if (mul_out_pd !== e.pd) $display("FAIL out_pd: got %h, required %h", mul_out_pd, e.pd);
                else n_pass++;
            end
            dat_fire  = dat_in_vld && dat_in_rdy;
            intp_fire = intp_in_vld && intp_in_rdy;
            n_chk++;
            if (dat_fire !== intp_fire) $display("FAIL join: dat_fire=%b intp_fire=%b, required equal", dat_fire, intp_fire);
            else n_pass++;
            if (dat_fire && intp_fire) begin
                exp_q.push_back(model(dat_in_pd, intp_in_pd, cfg_mul_shift, cfg_mul_bypass));
                s_fire = 1'b1;
                fire_count++;
            end
            prev_vld = mul_out_vld;
            prev_rdy = mul_out_rdy;
            prev_pd  = mul_out_pd;
            prev_clr = cnt_clr;
        end
        @(posedge nvdla_core_clk);
        #1;
    endtask

    task automatic send_one(input logic [16:0] d, input logic [16:0] c, input logic [4:0] s,
                            input logic b, input logic clr,
                            output logic [15:0] pd, output int lat, output logic ok);
        int n;
        dat_in_pd = d; intp_in_pd = c; cfg_mul_shift = s; cfg_mul_bypass = b;
        dat_in_vld = 1'b1; intp_in_vld = 1'b1; mul_out_rdy = 1'b1;
        n = 0;
        do begin cycle(); n++; end while (!s_fire && n < 20);
        dat_in_vld = 1'b0; intp_in_vld = 1'b0; cnt_clr = clr;
        ok = s_fire; lat = 0; pd = '0;
        while (ok) begin
            cycle();
            cnt_clr = 1'b0;
            lat++;
            if (s_out_vld && s_out_rdy) begin pd = s_out_pd; break; end
            if (lat > 20) ok = 1'b0;
        end
        cnt_clr = 1'b0;
    endtask

    task automatic test_reset();
        nvdla_core_rstn = 1'b0;
        dat_in_pd = '0; intp_in_pd = '0; dat_in_vld = 1'b0; intp_in_vld = 1'b0;
        cfg_mul_shift = '0; cfg_mul_bypass = 1'b0; cnt_clr = 1'b0; mul_out_rdy = 1'b0;
        cycle(); cycle();
        n_chk++; if (s_out_vld !== 1'b0) $display("FAIL reset_vld: got %b, required 0", s_out_vld); else n_pass++;
        n_chk++; if (s_out_pd !== 16'h0) $display("FAIL reset_pd: got %h, required 0000", s_out_pd); else n_pass++;
        n_chk++; if (s_sat_cnt !== 32'd0) $display("FAIL reset_sat_cnt: got %0d, required 0", s_sat_cnt); else n_pass++;
        nvdla_core_rstn = 1'b1;
        cycle();
    endtask

    task automatic test_one(input string name, input logic [16:0] d, input logic [16:0] c,
                            input logic [4:0] s, input logic b, input logic clr,
                            input logic [15:0] want_pd, input logic [31:0] want_cnt);
        logic [15:0] pd;
        int          lat;
        logic        ok;
        send_one(d, c, s, b, clr, pd, lat, ok);
        n_chk++;
        if (!ok || lat != 2) $display("FAIL %s_latency: ok=%b lat=%0d, required lat=2", name, ok, lat);
        else n_pass++;
        n_chk++;
        if (pd !== want_pd) $display("FAIL %s_pd: got %h, required %h", name, pd, want_pd);
        else n_pass++;
        n_chk++;
        if (s_sat_cnt !== want_cnt) $display("FAIL %s_sat_cnt: got %0d, required %0d", name, s_sat_cnt, want_cnt);
        else n_pass++;
    endtask

    task automatic test_basic();
        test_one("basic", 17'd100, 17'h00200, 5'd9, 1'b0, 1'b0, 16'd100, 32'd0);
    endtask

    task automatic test_round();
        test_one("round_neg", 17'h1FFFD, 17'd1, 5'd1, 1'b0, 1'b0, 16'hFFFF, 32'd0);
        test_one("round_pos", 17'd3, 17'd1, 5'd1, 1'b0, 1'b0, 16'd2, 32'd0);
    endtask

    task automatic test_saturate();
        test_one("sat_pos", 17'h0FFFF, 17'h0FFFF, 5'd0, 1'b0, 1'b0, 16'h7FFF, 32'd1);
        test_one("sat_neg", 17'h10000, 17'h0FFFF, 5'd0, 1'b0, 1'b0, 16'h8000, 32'd2);
    endtask

    task automatic test_bypass();
        test_one("bypass", 17'd40000, 17'($urandom), 5'($urandom), 1'b1, 1'b0, 16'h7FFF, 32'd3);
        test_one("bypass_clr", 17'd40000, 17'($urandom), 5'($urandom), 1'b1, 1'b1, 16'h7FFF, 32'd1);
    endtask

    task automatic test_sticky();
        logic [15:0] pd;
        int          lat;
        logic        ok;
        for (int i = 0; i < 8; i++) send_one(17'h10000 | 17'($urandom_range(0, 1000)), 17'd0, 5'd0, 1'b1, 1'b0, pd, lat, ok);
        n_chk++;
        if (s_sat_cnt !== 32'd9) $display("FAIL sticky_wide: got %0d, required 9", s_sat_cnt); else n_pass++;
        n_chk++;
        if (s_sat_cnt_s !== 3'd7) $display("FAIL sticky_narrow: got %0d, required 7", s_sat_cnt_s); else n_pass++;
    endtask

    task automatic test_gap();
        int o0, f0;
        o0 = out_count; f0 = fire_count;
        mul_out_rdy = 1'b1; cfg_mul_bypass = 1'b0; cfg_mul_shift = 5'd0;
        dat_in_pd = 17'd7; intp_in_pd = 17'd5;
        intp_in_vld = 1'b1; dat_in_vld = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            n_chk++;
            if (s_intp_rdy !== 1'b0) $display("FAIL gap_intp_rdy: cycle %0d got %b, required 0", i, s_intp_rdy); else n_pass++;
            n_chk++;
            if (s_dat_rdy !== 1'b1) $display("FAIL gap_dat_rdy: cycle %0d got %b, required 1", i, s_dat_rdy); else n_pass++;
        end
        dat_in_vld = 1'b1;
        cycle();
        n_chk++;
        if (s_fire !== 1'b1) $display("FAIL gap_join: fire=%b, required 1", s_fire); else n_pass++;
        dat_in_vld = 1'b0; intp_in_vld = 1'b0;
        for (int i = 0; i < 5; i++) cycle();
        n_chk++;
        if (out_count - o0 != 1 || fire_count - f0 != 1)
            $display("FAIL gap_count: outputs=%0d joins=%0d, required 1 and 1", out_count - o0, fire_count - f0);
        else n_pass++;
    endtask

    task automatic test_random();
        int f0, cyc;
        f0 = fire_count; cyc = 0;
        while (fire_count - f0 < 1000 && cyc < 20000) begin
            dat_in_vld     = ($urandom_range(0, 3) != 0);
            intp_in_vld    = ($urandom_range(0, 3) != 0);
            dat_in_pd      = 17'($urandom);
            intp_in_pd     = 17'($urandom);
            cfg_mul_shift  = 5'($urandom);
            cfg_mul_bypass = ($urandom_range(0, 7) == 0);
            mul_out_rdy    = 1'($urandom);
            cnt_clr        = ($urandom_range(0, 31) == 0);
            cycle();
            cyc++;
        end
        dat_in_vld = 1'b0; intp_in_vld = 1'b0; cnt_clr = 1'b0; mul_out_rdy = 1'b1;
        n_chk++;
        if (fire_count - f0 < 1000) $display("FAIL random_progress: joined %0d, required 1000", fire_count - f0); else n_pass++;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 20) begin cycle(); cyc++; end
        n_chk++;
        if (exp_q.size() != 0) $display("FAIL random_drain: %0d beats outstanding, required 0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int o0, cyc;
        o0 = out_count;
        mul_out_rdy = 1'b1; dat_in_vld = 1'b1; intp_in_vld = 1'b1;
        for (int i = 0; i < 20; i++) begin
            dat_in_pd = 17'($urandom); intp_in_pd = 17'($urandom);
            cfg_mul_shift = 5'($urandom_range(8, 20)); cfg_mul_bypass = 1'b0;
            cycle();
        end
        dat_in_vld = 1'b0; intp_in_vld = 1'b0;
        cycle(); cycle();
        n_chk++;
        if (out_count - o0 != 20) $display("FAIL b2b_throughput: outputs=%0d, required 20", out_count - o0); else n_pass++;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 20) begin cycle(); cyc++; end
    endtask

    task automatic test_mid_reset();
        mul_out_rdy = 1'b0; dat_in_vld = 1'b1; intp_in_vld = 1'b1;
        for (int i = 0; i < 4; i++) begin
            dat_in_pd = 17'($urandom); intp_in_pd = 17'($urandom); cfg_mul_shift = 5'd0;
            cycle();
        end
        dat_in_vld = 1'b0; intp_in_vld = 1'b0;
        nvdla_core_rstn = 1'b0;
        cycle();
        n_chk++;
        if (s_out_vld !== 1'b0 || s_sat_cnt !== 32'd0)
            $display("FAIL midreset_clear: vld=%b sat_cnt=%0d, required 0 and 0", s_out_vld, s_sat_cnt);
        else n_pass++;
        nvdla_core_rstn = 1'b1;
        cycle();
        test_one("after_reset", 17'h1FF9C, 17'h00200, 5'd9, 1'b0, 1'b0, 16'hFF9C, 32'd0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_round();
        test_saturate();
        test_bypass();
        test_sticky();
        test_gap();
        test_back_to_back();
        test_random();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
